sum_accumulator: RTL and testbench
==================================

# sum_accumulator

Downstream stage of the 4-bit combinational binary adder. Consumes its 4-bit modulo-16 sums one per cycle under a valid/ready handshake and accumulates a fixed-length frame of FRAME_LEN sums into a wider register. Presents the frame total with a sticky overflow flag on a held output handshake. Gives the datapath multi-operand summation without widening the adder itself.

## Interface
- ACC_W, default 8, accumulator and total width in bits; legal range 5..16.
- FRAME_LEN, default 4, number of sums per frame; legal range 1..255.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that opens a new frame; honoured only in IDLE.
- in_sum  input  4  sum from the adder, treated as unsigned 0..15.
- in_valid  input  1  in_sum is valid this cycle.
- in_ready  output  1  block accepts in_sum this cycle.
- out_total  output  ACC_W  frame total, modulo 2^ACC_W.
- out_ovf  output  1  sticky flag: frame total exceeded 2^ACC_W−1.
- out_valid  output  1  out_total and out_ovf are valid and held.
- out_ready  input  1  consumer takes the total.
- busy  output  1  high in ACCUM and DONE.
- count  output  8  number of sums accepted in the current frame.

## Operation
- States are IDLE, ACCUM and DONE. Reset enters IDLE.
- IDLE:
  - in_ready=0 and out_valid=0.
  - start=1 → ACCUM. On that edge: acc=0, ovf=0, count=0.
- ACCUM:
  - in_ready=1.
  - An accept is in_valid & in_ready. On each accept: acc ← (acc + zero-extended in_sum) mod 2^ACC_W, and count ← count+1.
  - ovf ← ovf | carry-out of that ACC_W-bit add.
  - When the accept makes count equal FRAME_LEN → DONE.
  - in_valid=0 cycles leave all state unchanged.
- DONE:
  - in_ready=0 and out_valid=1.
  - out_total=acc and out_ovf=ovf, both held stable until accepted.
  - out_valid & out_ready → IDLE. On that edge out_valid clears; out_total, out_ovf and count keep their last values.
- start outside IDLE is ignored. This includes the DONE cycle in which out_ready is high; a new frame needs start in a later IDLE cycle.
- FRAME_LEN=1: a single accept goes ACCUM→DONE.
- busy = (state != IDLE).

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Reset values: in_ready=0, out_valid=0, out_total=0, out_ovf=0, busy=0, count=0, state=IDLE.
- rst asserted in any state, including mid-frame and during DONE with out_valid high, fully reinitialises on the next edge. The partial frame is discarded.
- start high in cycle t → in_ready=1 from cycle t+1.
- Throughput is one sum per cycle. A gapless frame takes FRAME_LEN cycles in ACCUM.
- Last accept in cycle t → out_valid=1 with the final total in cycle t+1. in_ready is already 0 in t+1.
- Output handshake in cycle t → out_valid=0 in t+1. Earliest new start is in t+1, giving in_ready=1 in t+2.
- in_sum is sampled only on accept cycles. Values on non-accept cycles have no effect.

## Test plan
- Basic frame (ACC_W=8, FRAME_LEN=4): start, then sums 3,5,7,9 back-to-back → out_valid one cycle after the 4th accept, out_total=24, out_ovf=0, count=4. in_ready low from that cycle on.
- Overflow (ACC_W=5, FRAME_LEN=4): sums 15,15,15,15 → out_total=28 (60 mod 32), out_ovf=1. out_ovf first sets on the 3rd accept (45 > 31) internally and stays set.
- Bubbles and backpressure (ACC_W=8, FRAME_LEN=3):
  - Sums 1, 2 and 4, with in_valid low for 2 cycles between each → out_total=7.
  - Hold out_ready low for 10 cycles → out_valid, out_total=7 and in_ready=0 are stable throughout.
  - Raise out_ready → IDLE next cycle.
- Start handling: start pulses during ACCUM and during the DONE handshake cycle → ignored, and the frame total is unchanged. A start in the next IDLE cycle opens a new frame with acc=0 and count=0.
- Reset mid-frame: 2 of 4 sums accepted (6 and 6), then rst for 1 cycle → all outputs at reset values next cycle. A fresh frame of 1,1,1,1 → out_total=4.
- FRAME_LEN=1 corner: start, then sum 15 → out_valid the next cycle with out_total=15, out_ovf=0.

Source files
------------

// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder, the accumulator and the total consumer.
// The slave side is the accumulator; the master side is its environment.
interface sum_accumulator_if #(
    parameter int ACC_W = 8
);
    logic             start;
    logic [3:0]       in_sum;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] out_total;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [7:0]       count;

    modport slave (
        input  start, in_sum, in_valid, out_ready,
        output in_ready, out_total, out_ovf, out_valid, busy, count
    );

    modport master (
        output start, in_sum, in_valid, out_ready,
        input  in_ready, out_total, out_ovf, out_valid, busy, count
    );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates a frame of FRAME_LEN 4-bit adder sums into an ACC_W-bit total
// with a sticky overflow flag, presented on a held output handshake.
module sum_accumulator #(
    parameter int ACC_W     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    sum_accumulator_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [ACC_W:0]   sum_ext;
    logic [7:0]       cnt_inc;

    assign sum_ext = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, bus.in_sum};
    assign cnt_inc = cnt_q + 8'd1;

    // Next-state and datapath updates for the frame FSM.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = 8'd0;
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    acc_d = sum_ext[ACC_W-1:0];
                    ovf_d = ovf_q | sum_ext[ACC_W];
                    cnt_d = cnt_inc;
                    if (cnt_inc == 8'(FRAME_LEN)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, accumulator, overflow and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode only registered state, never an input.
    assign bus.in_ready  = (state_q == S_ACCUM);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_total = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.count     = cnt_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator across four parameter sets.
// Expected values are hand-computed frame totals.
module tb_sum_accumulator;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    sum_accumulator_if #(.ACC_W(8)) ifa ();
    sum_accumulator_if #(.ACC_W(5)) ifb ();
    sum_accumulator_if #(.ACC_W(8)) ifc ();
    sum_accumulator_if #(.ACC_W(8)) ifd ();

    sum_accumulator #(.ACC_W(8), .FRAME_LEN(4)) u_a (
        .clk (clk), .rst (rst), .bus (ifa.slave)
    );
    sum_accumulator #(.ACC_W(5), .FRAME_LEN(4)) u_b (
        .clk (clk), .rst (rst), .bus (ifb.slave)
    );
    sum_accumulator #(.ACC_W(8), .FRAME_LEN(3)) u_c (
        .clk (clk), .rst (rst), .bus (ifc.slave)
    );
    sum_accumulator #(.ACC_W(8), .FRAME_LEN(1)) u_d (
        .clk (clk), .rst (rst), .bus (ifd.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sa[4];
        int sc[3];
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        ifa.start = 0; ifa.in_sum = 0; ifa.in_valid = 0; ifa.out_ready = 0;
        ifb.start = 0; ifb.in_sum = 0; ifb.in_valid = 0; ifb.out_ready = 0;
        ifc.start = 0; ifc.in_sum = 0; ifc.in_valid = 0; ifc.out_ready = 0;
        ifd.start = 0; ifd.in_sum = 0; ifd.in_valid = 0; ifd.out_ready = 0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_in_ready", ifa.in_ready, 0);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_total", ifa.out_total, 0);
        chk("rst_ovf", ifa.out_ovf, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_count", ifa.count, 0);

        // Basic frame 3,5,7,9 -> 24
        sa = '{3, 5, 7, 9};
        ifa.start = 1;
        tick();
        ifa.start = 0;
        chk("a_start_ready", ifa.in_ready, 1);
        chk("a_start_busy", ifa.busy, 1);
        for (int i = 0; i < 4; i++) begin
            ifa.in_valid = 1;
            ifa.in_sum   = 4'(sa[i]);
            tick();
            if (i < 3) chk("a_valid_early", ifa.out_valid, 0);
        end
        ifa.in_valid = 0;
        chk("a_out_valid", ifa.out_valid, 1);
        chk("a_total", ifa.out_total, 24);
        chk("a_ovf", ifa.out_ovf, 0);
        chk("a_count", ifa.count, 4);
        chk("a_in_ready_done", ifa.in_ready, 0);

        // Start during the DONE handshake cycle is ignored
        ifa.out_ready = 1;
        ifa.start     = 1;
        tick();
        ifa.out_ready = 0;
        ifa.start     = 0;
        chk("a_idle_valid", ifa.out_valid, 0);
        chk("a_idle_busy", ifa.busy, 0);
        chk("a_idle_ready", ifa.in_ready, 0);
        chk("a_idle_total", ifa.out_total, 24);
        chk("a_idle_count", ifa.count, 4);

        // New frame; starts during ACCUM are ignored
        ifa.start = 1;
        tick();
        chk("a2_ready", ifa.in_ready, 1);
        chk("a2_count0", ifa.count, 0);
        chk("a2_total0", ifa.out_total, 0);
        ifa.in_valid = 1;
        ifa.in_sum   = 4'd2;
        tick();
        chk("a2_count1", ifa.count, 1);
        chk("a2_total1", ifa.out_total, 2);
        ifa.in_valid = 0;
        ifa.in_sum   = 4'd9;
        tick();
        ifa.start = 0;
        chk("a2_ign_count", ifa.count, 1);
        chk("a2_ign_total", ifa.out_total, 2);
        chk("a2_ign_ready", ifa.in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            ifa.in_valid = 1;
            ifa.in_sum   = 4'd1;
            tick();
        end
        ifa.in_valid = 0;
        chk("a2_valid", ifa.out_valid, 1);
        chk("a2_total", ifa.out_total, 5);
        ifa.out_ready = 1;
        tick();
        ifa.out_ready = 0;
        chk("a2_back_idle", ifa.busy, 0);

        // Reset mid-frame after 6,6
        ifa.start = 1;
        tick();
        ifa.start = 0;
        for (int i = 0; i < 2; i++) begin
            ifa.in_valid = 1;
            ifa.in_sum   = 4'd6;
            tick();
        end
        chk("a3_count2", ifa.count, 2);
        chk("a3_total12", ifa.out_total, 12);
        rst = 1;
        tick();
        rst = 0;
        ifa.in_valid = 0;
        chk("a3_rst_ready", ifa.in_ready, 0);
        chk("a3_rst_valid", ifa.out_valid, 0);
        chk("a3_rst_total", ifa.out_total, 0);
        chk("a3_rst_ovf", ifa.out_ovf, 0);
        chk("a3_rst_busy", ifa.busy, 0);
        chk("a3_rst_count", ifa.count, 0);
        ifa.start = 1;
        tick();
        ifa.start = 0;
        for (int i = 0; i < 4; i++) begin
            ifa.in_valid = 1;
            ifa.in_sum   = 4'd1;
            tick();
        end
        ifa.in_valid = 0;
        chk("a4_valid", ifa.out_valid, 1);
        chk("a4_total", ifa.out_total, 4);

        // Overflow: 15 x4 in 5 bits -> 28, ovf sticky from 3rd accept
        ifb.start = 1;
        tick();
        ifb.start = 0;
        for (int i = 0; i < 4; i++) begin
            ifb.in_valid = 1;
            ifb.in_sum   = 4'd15;
            tick();
            if (i == 1) begin
                chk("b_total2", ifb.out_total, 30);
                chk("b_ovf2", ifb.out_ovf, 0);
            end
            if (i == 2) begin
                chk("b_total3", ifb.out_total, 13);
                chk("b_ovf3", ifb.out_ovf, 1);
            end
        end
        ifb.in_valid = 0;
        chk("b_valid", ifb.out_valid, 1);
        chk("b_total", ifb.out_total, 28);
        chk("b_ovf", ifb.out_ovf, 1);

        // Bubbles and backpressure: 1,2,4 with 2-cycle gaps -> 7
        sc = '{1, 2, 4};
        ifc.start = 1;
        tick();
        ifc.start = 0;
        for (int i = 0; i < 3; i++) begin
            ifc.in_valid = 1;
            ifc.in_sum   = 4'(sc[i]);
            tick();
            ifc.in_valid = 0;
            ifc.in_sum   = 4'd15;
            if (i < 2) begin
                tick();
                tick();
            end
        end
        chk("c_valid", ifc.out_valid, 1);
        chk("c_total", ifc.out_total, 7);
        chk("c_count", ifc.count, 3);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("c_hold_valid", ifc.out_valid, 1);
            chk("c_hold_total", ifc.out_total, 7);
            chk("c_hold_ready", ifc.in_ready, 0);
        end
        ifc.out_ready = 1;
        tick();
        ifc.out_ready = 0;
        chk("c_idle_valid", ifc.out_valid, 0);
        chk("c_idle_busy", ifc.busy, 0);
        chk("c_idle_total", ifc.out_total, 7);

        // FRAME_LEN=1 corner
        ifd.start = 1;
        tick();
        ifd.start = 0;
        chk("d_ready", ifd.in_ready, 1);
        ifd.in_valid = 1;
        ifd.in_sum   = 4'd15;
        tick();
        ifd.in_valid = 0;
        chk("d_valid", ifd.out_valid, 1);
        chk("d_total", ifd.out_total, 15);
        chk("d_ovf", ifd.out_ovf, 0);
        chk("d_count", ifd.count, 1);
        chk("d_in_ready", ifd.in_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
